// File: rtl/param_mux_reg_pkg.sv
// Shared constants and helpers for the param_mux_reg word multiplexer.
// Imported by the top and its output-register sub-module.
package param_mux_reg_pkg;

   // Value driven onto every output bit when select addresses no input.
   localparam logic MUX_FILL_BIT = 1'b0;

   // Minimum select width able to address depth inputs.
   function automatic int unsigned sel_width_for(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/param_mux_reg_mux_out_reg.sv
// Enable-gated output register for the selected word and the select-range error flag.
// Asynchronous active-high reset clears both.
module param_mux_reg_mux_out_reg
   import param_mux_reg_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic [BIT_WIDTH-1:0] data_i,
   input  logic                 err_i,
   output logic [BIT_WIDTH-1:0] data_o,
   output logic                 err_o
);

   logic [BIT_WIDTH-1:0] data_d, data_q;
   logic                 err_d, err_q;

   always_comb begin
      data_d = data_q;
      err_d  = err_q;
      if (en_i) begin
         data_d = data_i;
         err_d  = err_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         err_q  <= err_d;
      end
   end

   assign data_o = data_q;
   assign err_o  = err_q;

endmodule

// File: rtl/param_mux_reg.sv
// Parameterized N:1 word multiplexer with a zero-latency output, a registered
// copy and a registered select-out-of-range flag.
module param_mux_reg
   import param_mux_reg_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 2,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned SEL_WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [BIT_WIDTH*DEPTH-1:0] dataIn,
   input  logic [SEL_WIDTH-1:0]       select,
   input  logic                       en,
   output logic [BIT_WIDTH-1:0]       muxout,
   output logic [BIT_WIDTH-1:0]       muxout_reg,
   output logic                       sel_err
);

   if (DEPTH < 2) begin : g_chk_depth
      $fatal(1, "param_mux_reg: DEPTH must be >= 2");
   end
   if (BIT_WIDTH < 1) begin : g_chk_width
      $fatal(1, "param_mux_reg: BIT_WIDTH must be >= 1");
   end
   if (SEL_WIDTH < sel_width_for(DEPTH)) begin : g_chk_sel
      $fatal(1, "param_mux_reg: 2**SEL_WIDTH must be >= DEPTH");
   end

   logic [DEPTH-1:0]     hit;
   logic [BIT_WIDTH-1:0] term [DEPTH];
   logic [BIT_WIDTH-1:0] or_word;
   logic [BIT_WIDTH-1:0] muxout_d;
   logic                 sel_err_d;

   // One-hot decode feeding an AND-OR tree; all slice bounds are elaboration constants.
   for (genvar k = 0; k < DEPTH; k++) begin : g_slice
      assign hit[k]  = (select == SEL_WIDTH'(k));
      assign term[k] = dataIn[k*BIT_WIDTH +: BIT_WIDTH] & {BIT_WIDTH{hit[k]}};
   end

   always_comb begin
      or_word = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         or_word = or_word | term[k];
      end
   end

   always_comb begin
      sel_err_d = ~(|hit);
      muxout_d  = sel_err_d ? {BIT_WIDTH{MUX_FILL_BIT}} : or_word;
   end

   assign muxout = muxout_d;

   param_mux_reg_mux_out_reg #(
      .BIT_WIDTH(BIT_WIDTH)
   ) u_mux_out_reg (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .data_i (muxout_d),
      .err_i  (sel_err_d),
      .data_o (muxout_reg),
      .err_o  (sel_err)
   );

endmodule

// File: tb/tb_param_mux_reg.sv
// Scoreboard bench for param_mux_reg: three parameterizations share one clock,
// reset and enable; expectations are queued by stimulus and checked on negedges.
module tb_param_mux_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;

   logic [7:0]  d0;
   logic [1:0]  s0;
   logic [1:0]  mux0, reg0;
   logic        err0;

   logic [11:0] d1;
   logic [1:0]  s1;
   logic [3:0]  mux1, reg1;
   logic        err1;

   logic [7:0]  d2;
   logic [2:0]  s2;
   logic [0:0]  mux2, reg2;
   logic        err2;

   typedef struct {
      int         dut;
      int         fld;
      logic [7:0] exp;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   param_mux_reg u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .dataIn     (d0),
      .select     (s0),
      .en         (en),
      .muxout     (mux0),
      .muxout_reg (reg0),
      .sel_err    (err0)
   );

   param_mux_reg #(
      .BIT_WIDTH(4),
      .DEPTH    (3),
      .SEL_WIDTH(2)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .dataIn     (d1),
      .select     (s1),
      .en         (en),
      .muxout     (mux1),
      .muxout_reg (reg1),
      .sel_err    (err1)
   );

   param_mux_reg #(
      .BIT_WIDTH(1),
      .DEPTH    (8),
      .SEL_WIDTH(3)
   ) u_dut2 (
      .clk        (clk),
      .rst        (rst),
      .dataIn     (d2),
      .select     (s2),
      .en         (en),
      .muxout     (mux2),
      .muxout_reg (reg2),
      .sel_err    (err2)
   );

   function automatic logic [7:0] actual(input int dut, input int fld);
      logic [7:0] v;
      v = 8'hxx;
      case (dut)
         0: v = (fld == 0) ? 8'(mux0) : (fld == 1) ? 8'(reg0) : 8'(err0);
         1: v = (fld == 0) ? 8'(mux1) : (fld == 1) ? 8'(reg1) : 8'(err1);
         default: v = (fld == 0) ? 8'(mux2) : (fld == 1) ? 8'(reg2) : 8'(err2);
      endcase
      return v;
   endfunction

   task automatic push(input int dut, input int fld, input logic [7:0] v, input string nm);
      exp_t e;
      e.dut  = dut;
      e.fld  = fld;
      e.exp  = v;
      e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the loading edge.
   initial begin
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            exp_t e;
            logic [7:0] a;
            e = sb_q.pop_front();
            a = actual(e.dut, e.fld);
            checks++;
            if (a !== e.exp) begin
               errors++;
               $display("FAIL %s dut%0d: got %h expected %h at %0t", e.name, e.dut, a, e.exp,
                        $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp0 [4];
      logic [7:0] exp1 [3];
      logic [7:0] exp8 [8];
      int         prev;
      exp0 = '{8'h3, 8'h2, 8'h1, 8'h0};
      exp1 = '{8'hC, 8'hB, 8'hA};
      exp8 = '{8'h0, 8'h1, 8'h0, 8'h0, 8'h1, 8'h1, 8'h0, 8'h1};

      rst = 1'b1;
      en  = 1'b0;
      d0  = 8'b00011011;
      s0  = 2'd0;
      d1  = 12'hABC;
      s1  = 2'd0;
      d2  = 8'b10110010;
      s2  = 3'd0;

      // Reset state, checked while rst is still high and clock is running.
      #2;
      push(0, 1, 8'h0, "reset_reg");
      push(0, 2, 8'h0, "reset_err");
      push(1, 1, 8'h0, "reset_reg");
      push(2, 1, 8'h0, "reset_reg");
      push(0, 0, 8'h3, "mux_in_reset");
      @(negedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b1;

      // Select sweep: combinational output and one-edge-later registered copy.
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         push(0, 1, exp0[prev], "reg_follow");
         push(0, 2, 8'h0, "err_inrange");
         s0 = 2'(i);
         push(0, 0, exp0[i], "mux_sweep");
         prev = i;
      end
      tick();
      push(0, 1, exp0[3], "reg_follow");

      // Asynchronous reset between edges while muxout_reg holds 2'b10.
      s0 = 2'd1;
      push(0, 0, 8'h2, "mux_sel1");
      tick();
      push(0, 1, 8'h2, "reg_pre_rst");
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      push(0, 1, 8'h0, "rst_async_reg");
      push(0, 2, 8'h0, "rst_async_err");
      push(0, 0, 8'h2, "rst_mux_kept");
      @(negedge clk);
      #1;
      rst = 1'b0;
      tick();
      push(0, 1, 8'h2, "reg_after_rst");

      // Enable low: muxout follows select, muxout_reg holds.
      s0 = 2'd0;
      tick();
      push(0, 1, 8'h3, "reg_load_hold");
      en = 1'b0;
      for (int s = 1; s < 4; s++) begin
         tick();
         s0 = 2'(s);
         push(0, 0, exp0[s], "mux_en0");
         push(0, 1, 8'h3, "reg_hold");
      end
      tick();
      push(0, 1, 8'h3, "reg_hold");
      en = 1'b1;

      // DEPTH=3: in-range sweep, then out-of-range select 3.
      for (int s = 0; s < 3; s++) begin
         tick();
         s1 = 2'(s);
         push(1, 0, exp1[s], "d3_mux");
      end
      tick();
      s1 = 2'd3;
      push(1, 0, 8'h0, "d3_mux_oor");
      tick();
      push(1, 2, 8'h1, "d3_err_set");
      push(1, 1, 8'h0, "d3_reg_oor");
      s1 = 2'd1;
      push(1, 0, 8'hB, "d3_mux_sel1");
      tick();
      push(1, 2, 8'h0, "d3_err_clr");
      push(1, 1, 8'hB, "d3_reg_sel1");

      // DEPTH=8, 1-bit: every index.
      for (int s = 0; s < 8; s++) begin
         tick();
         s2 = 3'(s);
         push(2, 0, exp8[s], "d8_mux");
      end

      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_mux_reg.md
Name: param_mux_reg

Overview:
Parameterized N:1 word multiplexer. Selects one BIT_WIDTH-bit slice out of a packed DEPTH-entry input bus.
- Primary output is combinational with zero latency.
- A registered copy and a select-range error flag are provided for timing-critical and protected consumers.
- Generic datapath/steering primitive used wherever one of several equal-width sources must be routed to a single sink.

Parameters:
- BIT_WIDTH, 2, width in bits of each mux input and of the output.
- DEPTH, 4, number of mux inputs; must be >= 2.
- SEL_WIDTH, 2, width of select; must satisfy 2**SEL_WIDTH >= DEPTH.

Ports:
- clk  input  1  system clock; registered outputs update on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- dataIn  input  BIT_WIDTH*DEPTH  packed inputs; input k occupies bits [k*BIT_WIDTH +: BIT_WIDTH], input 0 at the LSBs.
- select  input  SEL_WIDTH  index of the input to route.
- en  input  1  load enable for the registered outputs.
- muxout  output  BIT_WIDTH  combinational selected word.
- muxout_reg  output  BIT_WIDTH  registered selected word.
- sel_err  output  1  registered flag: select was out of range at the last enabled load.

Behaviour:
- muxout = dataIn[select*BIT_WIDTH +: BIT_WIDTH] when select < DEPTH.
  - Purely combinational; no clock or reset dependence.
  - Follows dataIn and select changes within the same delta.
- Out-of-range select (select >= DEPTH, possible only when DEPTH < 2**SEL_WIDTH): muxout = all zeros. Never X and never a wrapped index.
- Reset: rst high asynchronously forces muxout_reg = 0 and sel_err = 0, regardless of clk.
  - Both hold while rst is high.
  - First load occurs at the first rising clk edge with rst low.
- Rising clk edge, rst low, en high:
  - muxout_reg <= value muxout had just before the edge.
  - sel_err <= (select >= DEPTH).
- en low: both registers hold.
- Latency: muxout 0 cycles; muxout_reg and sel_err 1 cycle after the sampling edge.
- Reset asserted mid-operation: registers clear immediately; muxout is unaffected.
- Simultaneous select and dataIn change: muxout reflects the new pair only; no glitch requirement beyond settling within the cycle.
- No handshake and no internal state other than the two registers.
- Elaboration checks, failing with a fatal message:
  - DEPTH < 2
  - BIT_WIDTH < 1
  - 2**SEL_WIDTH < DEPTH

Decomposition:
- Shared package holds:
  - a clog2-based helper function for deriving SEL_WIDTH from DEPTH;
  - the out-of-range fill constant (all zeros).
- One natural sub-module, mux_out_reg: the enable-gated, async-reset output register for muxout_reg and sel_err.
- Selection logic stays in the top module as a generate/for-loop AND-OR tree (no variable part-select), so it is synthesis-friendly for any DEPTH.

Test Plan:
- Defaults, dataIn=8'b00011011, select stepped 0,1,2,3 at 10-time-unit intervals -> muxout = 2'b11, 2'b10, 2'b01, 2'b00 respectively, each settled before the next step.
- Same stimulus with en=1 and a clock running -> muxout_reg equals each value one rising edge after select changes; sel_err stays 0.
- rst pulsed high between clock edges while muxout_reg = 2'b10 -> muxout_reg and sel_err go 0 immediately; muxout unchanged; after release, the first edge reloads the current selection.
- en=0, select changed from 0 to 3 across several edges -> muxout follows to 2'b00; muxout_reg holds 2'b11.
- DEPTH=3, SEL_WIDTH=2, BIT_WIDTH=4, dataIn=12'hABC, select=3 -> muxout = 4'h0; after one enabled edge, sel_err = 1 and muxout_reg = 0. Then select=1 -> muxout = 4'hB; sel_err clears on the next enabled edge.
- DEPTH=8, BIT_WIDTH=1, dataIn=8'b10110010, all selects swept -> muxout equals dataIn[select] for every index.
